// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: RTS, start, 8 data bits LSB first, odd parity, stop, device ack.
// Optional watchdog abort under `PS2_TX_TIMEOUT_EN`. Lines are open-drain: driven 0 or released.
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    filter_reg;
  logic          f_val;
  logic          fall_edge;
  logic [8:0]    b_reg, b_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    n_reg, n_n;
  logic          done_reg, done_n;
  logic          timeout;

  // Filtered level only moves when eight consecutive samples agree.
  assign fall_edge = f_val && (filter_reg == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      filter_reg <= 8'h00;
      f_val      <= 1'b0;
      b_reg      <= '0;
      cnt        <= '0;
      n_reg      <= '0;
      done_reg   <= 1'b0;
    end else begin
      state      <= state_n;
      filter_reg <= {ps2c, filter_reg[7:1]};
      if (filter_reg == 8'hff)
        f_val <= 1'b1;
      else if (filter_reg == 8'h00)
        f_val <= 1'b0;
      b_reg      <= b_n;
      cnt        <= cnt_n;
      n_reg      <= n_n;
      done_reg   <= done_n;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WW-1:0] wd;
  logic          err_reg;
  logic          active;

  assign active  = (state == START) || (state == DATA) || (state == STOP);
  assign timeout = active && !fall_edge && (wd == WW'(TIMEOUT_CYCLES - 1));

  // Counter sits at 0 outside the device-clocked phase, so START entry starts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd      <= '0;
      err_reg <= 1'b0;
    end else begin
      wd      <= (active && !fall_edge && !timeout) ? wd + 1'b1 : '0;
      err_reg <= timeout;
    end
  end

  assign tx_err_tick = err_reg;
`else
  assign timeout     = 1'b0;
  assign tx_err_tick = 1'b0;
`endif

  always_comb begin
    state_n = state;
    b_n     = b_reg;
    cnt_n   = cnt;
    n_n     = n_reg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ps2) begin
          b_n     = {~^din, din};
          cnt_n   = CW'(RTS_CYCLES - 1);
          state_n = RTS;
        end
      end
      RTS: begin
        if (cnt == '0)
          state_n = START;
        else
          cnt_n = cnt - 1'b1;
      end
      START: begin
        if (fall_edge) begin
          n_n     = 4'd8;
          state_n = DATA;
        end
      end
      DATA: begin
        if (fall_edge) begin
          b_n = {1'b0, b_reg[8:1]};
          if (n_reg == 4'd0)
            state_n = STOP;
          else
            n_n = n_reg - 4'd1;
        end
      end
      STOP: begin
        if (fall_edge) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      done_n  = 1'b0;
    end
  end

  assign ps2c = (state == RTS) ? 1'b0 : 1'bz;
  assign ps2d = ((state == START) || ((state == DATA) && !b_reg[0])) ? 1'b0 : 1'bz;

  assign tx_idle      = (state == IDLE);
  assign tx_done_tick = done_reg;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard module. It sends one command byte, for example 0xED (set LEDs) or 0xFF (reset), to the keyboard over the shared ps2c/ps2d lines, using the standard request-to-send, device-clocked, odd-parity frame. Its `tx_idle` output drives the `rx_en` input of the PS/2 receiver, so the receiver ignores the lines while the block is transmitting.

## Interface
- `RTS_CYCLES`, default 10000: number of clk cycles ps2c is held low for request-to-send (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: watchdog limit in clk cycles between device clock edges. Used only with `PS2_TX_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `wr_ps2`  in  1  one-cycle request to transmit `din`. Sampled only in IDLE.
- `din`  in  8  command byte.
- `ps2c`  inout  1  PS/2 clock, open-drain: driven 0 or released to Z.
- `ps2d`  inout  1  PS/2 data, open-drain: driven 0 or released to Z.
- `tx_idle`  out  1  high in IDLE. Connects to the receiver's `rx_en`.
- `tx_done_tick`  out  1  one-cycle pulse when the frame completes.
- `tx_err_tick`  out  1  one-cycle pulse on watchdog abort. Constant 0 without the macro.

## Operation
**Clock filter**
- 8-bit shift register samples ps2c every clk.
- The filtered level goes to 1 when all 8 samples are 1, goes to 0 when all 8 are 0, and otherwise holds.
- `fall_edge` pulses for one cycle when the filtered level changes 1→0.
- Reset clears the shift register and the filtered level to 0.

**Frame**
- `b_reg[8:0]` = {~^din, din}, giving odd parity. Bits are shifted out LSB first.
- Lines are driven only with 0; a 1 bit releases the line (Z).

**FSM: IDLE, RTS, START, DATA, STOP**
- IDLE
  - Both lines released; `tx_idle`=1.
  - On `wr_ps2`: load `b_reg`, load counter = RTS_CYCLES-1, go to RTS.
- RTS
  - ps2c driven 0; ps2d released.
  - Counter decrements each cycle; at 0, go to START.
- START
  - ps2c released; ps2d driven 0 (start bit).
  - On `fall_edge`: bit count n=8, go to DATA.
- DATA
  - ps2d = 0 if `b_reg[0]`=0, otherwise released.
  - On `fall_edge`: shift `b_reg` right.
  - If n=0 on that edge, go to STOP; else decrement n.
  - 9 edges in total (8 data bits + parity).
- STOP
  - Both lines released (stop bit = 1 via pull-up).
  - On `fall_edge` (device ack clock): go to IDLE and pulse `tx_done_tick`.
- Every frame consumes exactly 11 filtered falling edges after RTS. The ack data value is not checked.

**Boundary conditions**
- `wr_ps2` outside IDLE is ignored; no queuing.
- `reset` in any state: next cycle is IDLE, both lines released, `b_reg`/counters cleared.
- `wr_ps2` together with `reset`: reset wins.
- Edges seen in IDLE or RTS are ignored.

## Timing
- Reset values: state IDLE, `tx_idle`=1, `tx_done_tick`=0, `tx_err_tick`=0, ps2c and ps2d both Z.
- All outputs and line enables are decoded from the registered state and `b_reg`.
- `wr_ps2` at cycle t:
  - `tx_idle`=0 and ps2c=0 from t+1.
  - ps2c held low for exactly RTS_CYCLES cycles.
  - START (ps2c released, ps2d low) at t+1+RTS_CYCLES.
- `fall_edge` occurs 8 to 9 clk cycles after the physical ps2c fall.
- The data change for the next bit is visible the cycle after `fall_edge`.
- `tx_done_tick` is high in the cycle the FSM enters IDLE, concurrent with `tx_idle`=1.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - Watchdog counter clears on entry to START and on every `fall_edge`.
  - It counts in START, DATA and STOP.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, release both lines, pulse `tx_err_tick` for one cycle, no `tx_done_tick`.
- Not defined: no watchdog logic; `tx_err_tick` is tied 0. A silent device leaves the block in its current state until reset.

## Test plan
- `din`=0xED, device model clocks 11 falls → ps2c low 10000 cycles; device samples 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1; one `tx_done_tick`; `tx_idle`=1 after.
- `din`=0x01 → parity bit 0 (ps2d driven low); `din`=0xFF → parity 1 (ps2d released).
- `wr_ps2` with `din`=0x00 pulsed during DATA of a 0xED frame → ignored; frame bits unchanged; exactly one `tx_done_tick`.
- 5-cycle low glitch on ps2c during DATA → no `fall_edge`; bit count unchanged; frame still completes after 11 real edges.
- `reset` asserted after the 4th data edge → next cycle IDLE, both lines Z, `tx_idle`=1, no `tx_done_tick`; a new `wr_ps2` restarts from RTS.
- With `PS2_TX_TIMEOUT_EN` and TIMEOUT_CYCLES=1000, device stops after 3 edges → `tx_err_tick` pulse 1000 cycles after the last `fall_edge`, lines released; without the macro the block stays in DATA.
